sha_pad_stream: RTL and testbench

- Parametrised SHA message padder/blocker. Takes a byte stream of message beats, each W_BEAT_B bytes wide with valid/ready, and emits whole hash blocks.
- Emitted blocks are big-endian and fully padded: the 0x80 marker, zero fill, and the big-endian bit-length field.
- Supports SHA-512 mode (128-byte block, 16-byte length field) and SHA-256 mode (64-byte block, 8-byte length field).
- Sits between the message ingress and the SHA compression cores. Unlike the previous pre-padder it has output backpressure, a parametrised beat width, byte-granular last beats and a size-mismatch check.

---
 rtl/sha_pad_stream.sv | 196 +++++++++++++++++++
 tb/tb_sha_pad_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_pad_stream.sv
// SHA-256/512 message padder: packs byte beats into big-endian blocks,
// appends the 0x80 marker, zero fill and the bit-length field.
module sha_pad_stream #(
    parameter int W_BEAT_B = 64,
    parameter int MODE_512 = 1,
    parameter int W_SZ     = 11,
    parameter int W_M      = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_v,
    output logic                                  i_r,
    input  logic                                  i_e,
    input  logic [$clog2(W_BEAT_B):0]             i_emp,
    input  logic [W_SZ-1:0]                       i_sz,
    input  logic [W_M-1:0]                        i_m,
    input  logic [W_BEAT_B*8-1:0]                 i_d,
    output logic                                  o_v,
    input  logic                                  o_r,
    output logic                                  o_f,
    output logic                                  o_l,
    output logic [3:0]                            o_c,
    output logic                                  o_err,
    output logic [W_M-1:0]                        o_m,
    output logic [((MODE_512 != 0) ? 128 : 64)*8-1:0] o_d
);
    localparam int BLK_B = (MODE_512 != 0) ? 128 : 64;
    localparam int LEN_B = (MODE_512 != 0) ? 16 : 8;
    localparam int OW    = $clog2(BLK_B);
    localparam int EW    = $clog2(W_BEAT_B) + 1;
    localparam int CW    = W_SZ + 1;
    localparam int MAXSZ = (1 << W_SZ) - 1;

    typedef enum logic [1:0] {ACC, PADLEN, LEN} st_t;

    st_t                r_st;
    logic               r_first;
    logic               r_pf;
    logic               r_ovf;
    logic               r_errl;
    logic [OW-1:0]      r_off;
    logic [CW-1:0]      r_cnt;
    logic [W_SZ-1:0]    r_sz;
    logic [3:0]         r_c;
    logic [W_M-1:0]     r_m;
    logic [LEN_B*8-1:0] r_lenf;
    logic [BLK_B*8-1:0] r_buf;

    logic               w_ofree;
    logic               w_acc;
    logic [EW-1:0]      w_nv;
    logic [OW:0]        w_used;
    logic [OW:0]        w_rem;
    logic [CW:0]        w_sum;
    logic               w_ovf;
    logic [CW-1:0]      w_cnt;
    logic [LEN_B*8-1:0] w_lenf;
    logic [W_SZ-1:0]    w_sz;
    logic [W_M-1:0]     w_m;
    logic [W_SZ+1:0]    w_csum;
    logic [3:0]         w_c;
    logic               w_err;
    logic               w_f;
    logic               w_full;
    logic               w_ld;
    logic               w_big;
    logic [BLK_B*8-1:0] w_blk;
    logic [BLK_B*8-1:0] w_tail;

    assign w_ofree = !o_v || o_r;
    assign i_r     = (r_st == ACC) && w_ofree;
    assign w_acc   = i_v && i_r;
    assign w_nv    = i_e ? (EW'(W_BEAT_B) - i_emp) : EW'(W_BEAT_B);
    assign w_used  = {1'b0, r_off} + (OW+1)'(w_nv);
    assign w_rem   = (OW+1)'(BLK_B) - w_used;
    assign w_sum   = {1'b0, r_cnt} + (CW+1)'(w_nv);
    assign w_ovf   = w_sum > (CW+1)'(MAXSZ);
    assign w_cnt   = w_ovf ? CW'(MAXSZ) : w_sum[CW-1:0];
    assign w_lenf  = (LEN_B*8)'({w_cnt, 3'b000});
    assign w_sz    = r_first ? i_sz : r_sz;
    assign w_m     = r_first ? i_m : r_m;
    assign w_csum  = {2'b00, i_sz} + (W_SZ+2)'(BLK_B + LEN_B);
    assign w_c     = r_first ? 4'(w_csum >> OW) : r_c;
    assign w_err   = (w_cnt != {1'b0, w_sz}) || w_ovf
                     || (!r_first && r_ovf);
    assign w_f     = r_first || r_pf;
    assign w_full  = (r_off == OW'(BLK_B - W_BEAT_B));
    assign w_ld    = w_full || i_e;
    assign w_big   = i_e && (w_rem >= (OW+1)'(LEN_B + 1));

    // Merge the incoming beat (and padding on a last beat) into the block.
    always_comb begin
        w_blk = r_buf;
        for (int k = 0; k < BLK_B; k++) begin
            if (k >= int'(r_off) && k < int'(r_off) + W_BEAT_B) begin
                if (k - int'(r_off) < int'(w_nv))
                    w_blk[BLK_B*8-1-8*k -: 8] =
                        i_d[8*(k-int'(r_off)) +: 8];
                else
                    w_blk[BLK_B*8-1-8*k -: 8] = 8'h00;
            end
            if (i_e && k == int'(w_used))
                w_blk[BLK_B*8-1-8*k -: 8] = 8'h80;
        end
        if (w_big)
            w_blk[LEN_B*8-1:0] = w_lenf;
    end

    // Trailing block: length only, plus the marker when data ended flush.
    always_comb begin
        w_tail = '0;
        w_tail[LEN_B*8-1:0] = r_lenf;
        if (r_st == PADLEN)
            w_tail[BLK_B*8-1 -: 8] = 8'h80;
    end

    // Block assembly FSM and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st    <= ACC;
            r_first <= 1'b1;
            r_pf    <= 1'b0;
            r_ovf   <= 1'b0;
            r_errl  <= 1'b0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_sz    <= '0;
            r_c     <= '0;
            r_m     <= '0;
            r_lenf  <= '0;
            r_buf   <= '0;
            o_v     <= 1'b0;
            o_f     <= 1'b0;
            o_l     <= 1'b0;
            o_c     <= '0;
            o_err   <= 1'b0;
            o_m     <= '0;
            o_d     <= '0;
        end else begin
            if (o_v && o_r)
                o_v <= 1'b0;
            unique case (r_st)
                ACC: begin
                    if (w_acc) begin
                        r_cnt   <= w_cnt;
                        r_ovf   <= w_ovf || (!r_first && r_ovf);
                        r_sz    <= w_sz;
                        r_m     <= w_m;
                        r_c     <= w_c;
                        r_first <= i_e;
                        if (w_ld) begin
                            o_v   <= 1'b1;
                            o_d   <= w_blk;
                            o_f   <= w_f;
                            o_c   <= w_c;
                            o_m   <= w_m;
                            o_l   <= w_big;
                            o_err <= w_big && w_err;
                            r_buf <= '0;
                            r_off <= '0;
                            r_pf  <= 1'b0;
                        end else begin
                            r_buf <= w_blk;
                            r_off <= r_off + OW'(W_BEAT_B);
                            r_pf  <= w_f;
                        end
                        if (i_e) begin
                            r_cnt  <= '0;
                            r_ovf  <= 1'b0;
                            r_lenf <= w_lenf;
                            r_errl <= w_err;
                            if (w_rem == '0)
                                r_st <= PADLEN;
                            else if (!w_big)
                                r_st <= LEN;
                        end
                    end
                end
                PADLEN, LEN: begin
                    if (w_ofree) begin
                        o_v   <= 1'b1;
                        o_d   <= w_tail;
                        o_f   <= r_pf;
                        o_l   <= 1'b1;
                        o_err <= r_errl;
                        o_c   <= r_c;
                        o_m   <= r_m;
                        r_pf  <= 1'b0;
                        r_st  <= ACC;
                    end
                end
                default: r_st <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_pad_stream.sv
// Scoreboard bench for sha_pad_stream: a SHA-512 / 64-byte-beat instance
// and a SHA-256 / 16-byte-beat instance checked against a padding model.
module tb_sha_pad_stream;
    logic clk = 1'b0;
    logic rst;

    logic          i_v_a, i_e_a, i_r_a, o_v_a, o_r_a;
    logic          o_f_a, o_l_a, o_err_a;
    logic [6:0]    i_emp_a;
    logic [10:0]   i_sz_a;
    logic [63:0]   i_m_a, o_m_a;
    logic [511:0]  i_d_a;
    logic [3:0]    o_c_a;
    logic [1023:0] o_d_a;

    logic          i_v_b, i_e_b, i_r_b, o_v_b, o_r_b;
    logic          o_f_b, o_l_b, o_err_b;
    logic [4:0]    i_emp_b;
    logic [10:0]   i_sz_b;
    logic [63:0]   i_m_b, o_m_b;
    logic [127:0]  i_d_b;
    logic [3:0]    o_c_b;
    logic [511:0]  o_d_b;

    typedef struct {
        logic          f;
        logic          l;
        logic          err;
        logic [3:0]    c;
        logic [63:0]   m;
        logic [1023:0] d;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] g_msg[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    sha_pad_stream #(.W_BEAT_B(64), .MODE_512(1), .W_SZ(11), .W_M(64))
    u_a (
        .clk(clk), .rst(rst),
        .i_v(i_v_a), .i_r(i_r_a), .i_e(i_e_a), .i_emp(i_emp_a),
        .i_sz(i_sz_a), .i_m(i_m_a), .i_d(i_d_a),
        .o_v(o_v_a), .o_r(o_r_a), .o_f(o_f_a), .o_l(o_l_a),
        .o_c(o_c_a), .o_err(o_err_a), .o_m(o_m_a), .o_d(o_d_a)
    );

    sha_pad_stream #(.W_BEAT_B(16), .MODE_512(0), .W_SZ(11), .W_M(64))
    u_b (
        .clk(clk), .rst(rst),
        .i_v(i_v_b), .i_r(i_r_b), .i_e(i_e_b), .i_emp(i_emp_b),
        .i_sz(i_sz_b), .i_m(i_m_b), .i_d(i_d_b),
        .o_v(o_v_b), .o_r(o_r_b), .o_f(o_f_b), .o_l(o_l_b),
        .o_c(o_c_b), .o_err(o_err_b), .o_m(o_m_b), .o_d(o_d_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic mk(input int n);
        g_msg.delete();
        for (int i = 0; i < n; i++)
            g_msg.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic push_exp(input int sel, input int sz,
                            input logic [63:0] m);
        int         blk, lb, n, nblk;
        logic [7:0] p[$];
        logic [127:0] lenv;
        exp_t       e;
        blk = (sel == 0) ? 128 : 64;
        lb  = (sel == 0) ? 16 : 8;
        n   = g_msg.size();
        p   = g_msg;
        p.push_back(8'h80);
        while ((p.size() % blk) != blk - lb)
            p.push_back(8'h00);
        lenv = 128'(n) << 3;
        for (int i = 0; i < lb; i++)
            p.push_back(lenv[(lb-1-i)*8 +: 8]);
        nblk = p.size() / blk;
        for (int b = 0; b < nblk; b++) begin
            e.f   = (b == 0);
            e.l   = (b == nblk - 1);
            e.err = e.l && (n != sz);
            e.c   = 4'((sz + 1 + lb + blk - 1) / blk);
            e.m   = m;
            e.d   = '0;
            for (int k = 0; k < blk; k++)
                e.d[(blk-1-k)*8 +: 8] = p[b*blk + k];
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    task automatic drive_beat(input int sel, input logic [511:0] beat,
                              input logic last, input int emp);
        logic ok;
        if (sel == 0) begin
            i_v_a = 1'b1; i_d_a = beat; i_e_a = last; i_emp_a = 7'(emp);
        end else begin
            i_v_b = 1'b1; i_d_b = beat[127:0]; i_e_b = last;
            i_emp_b = 5'(emp);
        end
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            ok = (sel == 0) ? i_r_a : i_r_b;
            @(posedge clk);
            #1;
        end
        if (!ok) check("beat_timeout", 256'(ok), 256'(1));
        if (sel == 0) i_v_a = 1'b0;
        else          i_v_b = 1'b0;
    endtask

    task automatic send(input int sel, input int sz, input logic [63:0] m);
        int bw, n, nb, idx;
        logic [511:0] beat;
        bw = (sel == 0) ? 64 : 16;
        n  = g_msg.size();
        nb = (n == 0) ? 1 : (n + bw - 1) / bw;
        push_exp(sel, sz, m);
        if (sel == 0) begin i_sz_a = 11'(sz); i_m_a = m; end
        else          begin i_sz_b = 11'(sz); i_m_b = m; end
        for (int b = 0; b < nb; b++) begin
            beat = '0;
            for (int j = 0; j < bw; j++) begin
                idx = b * bw + j;
                if (idx < n) beat[8*j +: 8] = g_msg[idx];
            end
            drive_beat(sel, beat, b == nb - 1,
                       (b == nb - 1) ? nb * bw - n : 0);
        end
    endtask

    // Scoreboard for the SHA-512 instance.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst && o_v_a && o_r_a) begin
            if (q_a.size() == 0) begin
                check("a_extra_blk", 256'(o_v_a), 256'(0));
            end else begin
                e = q_a.pop_front();
                check("a_f", 256'(o_f_a), 256'(e.f));
                check("a_l", 256'(o_l_a), 256'(e.l));
                check("a_c", 256'(o_c_a), 256'(e.c));
                check("a_err", 256'(o_err_a), 256'(e.err));
                check("a_m", 256'(o_m_a), 256'(e.m));
                for (int i = 0; i < 4; i++)
                    check($sformatf("a_d%0d", i), o_d_a[i*256 +: 256],
                          e.d[i*256 +: 256]);
            end
        end
    end

    // Scoreboard for the SHA-256 instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst && o_v_b && o_r_b) begin
            if (q_b.size() == 0) begin
                check("b_extra_blk", 256'(o_v_b), 256'(0));
            end else begin
                e = q_b.pop_front();
                check("b_f", 256'(o_f_b), 256'(e.f));
                check("b_l", 256'(o_l_b), 256'(e.l));
                check("b_c", 256'(o_c_b), 256'(e.c));
                check("b_err", 256'(o_err_b), 256'(e.err));
                check("b_m", 256'(o_m_b), 256'(e.m));
                for (int i = 0; i < 2; i++)
                    check($sformatf("b_d%0d", i), o_d_b[i*256 +: 256],
                          e.d[i*256 +: 256]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] snap;
        logic [511:0] beat;
        int t;
        rst = 1'b1;
        i_v_a = 0; i_e_a = 0; i_emp_a = 0; i_sz_a = 0; i_m_a = 0; i_d_a = 0;
        i_v_b = 0; i_e_b = 0; i_emp_b = 0; i_sz_b = 0; i_m_b = 0; i_d_b = 0;
        o_r_a = 1'b1;
        o_r_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ov_a", 256'(o_v_a), 256'(0));
        check("rst_of_a", 256'(o_f_a), 256'(0));
        check("rst_ol_a", 256'(o_l_a), 256'(0));
        check("rst_oerr_a", 256'(o_err_a), 256'(0));
        check("rst_oc_a", 256'(o_c_a), 256'(0));
        check("rst_om_a", 256'(o_m_a), 256'(0));
        check("rst_od_a", 256'(|o_d_a), 256'(0));
        check("rst_ir_a", 256'(i_r_a), 256'(1));
        check("rst_ov_b", 256'(o_v_b), 256'(0));
        check("rst_ir_b", 256'(i_r_b), 256'(1));
        @(posedge clk);
        #1;

        mk(0);   send(0, 0, 64'h1111_0000_0000_0001);
        mk(111); send(0, 111, 64'h2222_0000_0000_0002);
        mk(112); send(0, 112, 64'h3333_0000_0000_0003);
        mk(128); send(0, 128, 64'h4444_0000_0000_0004);
        mk(12);  send(0, 10, 64'h5555_0000_0000_0005);

        o_r_b = 1'b0;
        mk(56);
        send(1, 56, 64'h6666_0000_0000_0006);
        for (t = 0; t < 50 && !o_v_b; t++) @(negedge clk);
        check("b_stall_ov", 256'(o_v_b), 256'(1));
        @(negedge clk);
        snap = o_d_b;
        repeat (5) begin
            @(negedge clk);
            check("b_stall_lo", o_d_b[255:0], snap[255:0]);
            check("b_stall_hi", o_d_b[511:256], snap[511:256]);
            check("b_stall_ir", 256'(i_r_b), 256'(0));
        end
        @(posedge clk);
        #1 o_r_b = 1'b1;
        mk(100); send(1, 100, 64'h7777_0000_0000_0007);
        repeat (6) @(posedge clk);
        #1;

        o_r_a = 1'b0;
        i_sz_a = 11'd200;
        i_m_a = 64'hdead;
        for (int b = 0; b < 2; b++) begin
            beat = {16{32'($urandom)}};
            drive_beat(0, beat, 1'b0, 0);
        end
        @(negedge clk);
        check("a_held_ov", 256'(o_v_a), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("a_rst_ov", 256'(o_v_a), 256'(0));
        check("a_rst_ir", 256'(i_r_a), 256'(1));
        @(posedge clk);
        #1 o_r_a = 1'b1;
        mk(20);  send(0, 20, 64'h8888_0000_0000_0008);
        mk(200); send(0, 200, 64'h9999_0000_0000_0009);

        for (t = 0; t < 500 && (q_a.size() + q_b.size()) > 0; t++)
            @(posedge clk);
        @(negedge clk);
        check("drain", 256'(q_a.size() + q_b.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
